// File: rtl/axis_uart_tx_arbiter.sv
// axis_uart_tx_arbiter: round-robin, packet-locked arbiter sharing one AXIS stream among NUM_SRC sources,
// with an optional source-ID header beat and forced termination after MAX_BEATS payload beats.
module axis_uart_tx_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int WIDTH = 8,
   parameter bit HDR_EN = 1'b1,
   parameter logic [WIDTH-1:0] HDR_BASE = WIDTH'('hA0),
   parameter int MAX_BEATS = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_SRC*WIDTH-1:0]     s_axis_data,
   input  logic [NUM_SRC-1:0]           s_axis_valid,
   input  logic [NUM_SRC-1:0]           s_axis_last,
   output logic [NUM_SRC-1:0]           s_axis_ready,
   output logic [WIDTH-1:0]             m_axis_data,
   output logic                         m_axis_valid,
   output logic                         m_axis_last,
   input  logic                         m_axis_ready,
   output logic [$clog2(NUM_SRC)-1:0]   grant_id,
   output logic                         busy,
   output logic                         timeout_err
);
   localparam int IW = $clog2(NUM_SRC);
   localparam int CW = $clog2(MAX_BEATS + 1);
   typedef enum logic [1:0] {IDLE, HDR, PASS} state_t;
   state_t state, state_n;
   logic [IW-1:0] rr_ptr, pick;
   logic [CW-1:0] beat_cnt;
   logic any, free, hs, load, load_last, at_max, tmo;
   logic [WIDTH-1:0] load_data, src_data;
   assign free = !m_axis_valid || m_axis_ready;
   assign busy = state != IDLE;
   assign at_max = beat_cnt == CW'(MAX_BEATS - 1);
   assign src_data = s_axis_data[int'(grant_id)*WIDTH +: WIDTH];
   // Scan from the farthest offset down so the nearest requester after rr_ptr wins.
   always_comb begin
      pick = rr_ptr;
      any = 1'b0;
      for (int k = NUM_SRC; k >= 1; k--)
         if (s_axis_valid[(int'(rr_ptr) + k) % NUM_SRC]) begin
            pick = IW'((int'(rr_ptr) + k) % NUM_SRC);
            any = 1'b1;
         end
   end
   always_comb begin
      state_n = state;
      s_axis_ready = '0;
      hs = 1'b0;
      load = 1'b0;
      load_data = src_data;
      load_last = 1'b0;
      tmo = 1'b0;
      case (state)
         IDLE: if (any) state_n = HDR_EN ? HDR : PASS;
         HDR: if (free) begin
            load = 1'b1;
            load_data = HDR_BASE + WIDTH'(grant_id);
            state_n = PASS;
         end
         PASS: begin
            s_axis_ready[grant_id] = free;
            hs = free && s_axis_valid[grant_id];
            load = hs;
            load_last = s_axis_last[grant_id] || at_max;
            tmo = hs && at_max && !s_axis_last[grant_id];
            if (hs && load_last) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         rr_ptr <= IW'(NUM_SRC - 1);
         grant_id <= '0;
         beat_cnt <= '0;
         m_axis_data <= '0;
         m_axis_valid <= 1'b0;
         m_axis_last <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_n;
         timeout_err <= tmo;
         if (state == IDLE && any) begin
            grant_id <= pick;
            rr_ptr <= pick;
            beat_cnt <= '0;
         end else if (hs && beat_cnt != CW'(MAX_BEATS))
            beat_cnt <= beat_cnt + CW'(1);
         if (load) begin
            m_axis_data <= load_data;
            m_axis_last <= load_last;
            m_axis_valid <= 1'b1;
         end else if (m_axis_ready)
            m_axis_valid <= 1'b0;
      end
endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// tb_axis_uart_tx_arbiter: directed bench with a packet-level round-robin model and a per-cycle scoreboard;
// lane 0 runs the header variant, lane 1 the header-less variant.
module tb_axis_uart_tx_arbiter;
   localparam int NS = 4, W = 8, MAXB = 16;
   localparam logic [7:0] HB = 8'hA0;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic [NS*W-1:0] s_data [2];
   logic [NS-1:0] s_valid [2], s_last [2], s_ready [2];
   logic [W-1:0] m_data [2];
   logic m_valid [2], m_last [2], m_ready [2], busy [2], terr [2];
   logic [1:0] gid [2];
   axis_uart_tx_arbiter #(.NUM_SRC(NS), .WIDTH(W), .HDR_EN(1'b1), .HDR_BASE(HB), .MAX_BEATS(MAXB)) dut (
      .clk(clk), .rst(rst), .s_axis_data(s_data[0]), .s_axis_valid(s_valid[0]), .s_axis_last(s_last[0]),
      .s_axis_ready(s_ready[0]), .m_axis_data(m_data[0]), .m_axis_valid(m_valid[0]), .m_axis_last(m_last[0]),
      .m_axis_ready(m_ready[0]), .grant_id(gid[0]), .busy(busy[0]), .timeout_err(terr[0]));
   axis_uart_tx_arbiter #(.NUM_SRC(NS), .WIDTH(W), .HDR_EN(1'b0), .HDR_BASE(HB), .MAX_BEATS(MAXB)) dut_nohdr (
      .clk(clk), .rst(rst), .s_axis_data(s_data[1]), .s_axis_valid(s_valid[1]), .s_axis_last(s_last[1]),
      .s_axis_ready(s_ready[1]), .m_axis_data(m_data[1]), .m_axis_valid(m_valid[1]), .m_axis_last(m_last[1]),
      .m_axis_ready(m_ready[1]), .grant_id(gid[1]), .busy(busy[1]), .timeout_err(terr[1]));
   // Source beats are {last, data}; expected beats are {check_gid, gid, last, data}.
   logic [8:0] sq [2*NS][$];
   logic [11:0] exq [2][$];
   bit rdyq [$];
   int gap [2*NS], gap_len [2*NS];
   logic [NS-1:0] hs [2];
   bit stall [2];
   logic [W+1:0] prev [2];
   int mptr [2], tcnt [2], texp [2];
   int nchk = 0, nerr = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic add_pkt(input int l, input int s, input int n, input logic [7:0] base);
      for (int j = 0; j < n; j++) sq[l*NS+s].push_back({j == n - 1, 8'(base + j)});
   endtask
   // Packet-level model: serve the next non-empty source after the last grant, up to MAXB beats per grant.
   task automatic build(input int ln);
      logic [8:0] q [NS][$];
      logic [8:0] b;
      int p, cnt;
      bit found, lst, first;
      p = 0;
      for (int i = 0; i < NS; i++) q[i] = sq[ln*NS+i];
      while (1) begin
         found = 0;
         for (int k = 1; k <= NS; k++)
            if (!found && q[(mptr[ln] + k) % NS].size() != 0) begin
               p = (mptr[ln] + k) % NS;
               found = 1;
            end
         if (!found) break;
         mptr[ln] = p;
         if (ln == 0) exq[0].push_back({1'b1, 2'(p), 1'b0, 8'(HB + p)});
         cnt = 0;
         first = ln == 1;
         lst = 0;
         while (!lst && q[p].size() != 0) begin
            b = q[p].pop_front();
            cnt++;
            lst = b[8] || cnt == MAXB;
            if (lst && !b[8]) texp[ln]++;
            exq[ln].push_back({first, 2'(p), lst, b[7:0]});
            first = 0;
         end
      end
   endtask
   task automatic tick();
      logic [11:0] e;
      @(negedge clk);
      for (int l = 0; l < 2; l++)
         for (int i = 0; i < NS; i++) begin
            int q;
            q = l*NS + i;
            if (hs[l][i]) begin
               void'(sq[q].pop_front());
               gap[q] = gap_len[q];
            end
            s_valid[l][i] = gap[q] == 0 && sq[q].size() != 0;
            if (sq[q].size() != 0) begin
               s_data[l][i*W +: W] = sq[q][0][7:0];
               s_last[l][i] = sq[q][0][8];
            end
            if (gap[q] > 0) gap[q]--;
         end
      m_ready[0] = rdyq.size() != 0 ? rdyq.pop_front() : 1'b1;
      m_ready[1] = 1'b1;
      #1;
      for (int l = 0; l < 2; l++) begin
         chk("ready_onehot", 32'($onehot0(s_ready[l])), 1);
         if (stall[l]) chk("hold_stable", 32'({m_valid[l], m_last[l], m_data[l]}), 32'(prev[l]));
         if (m_valid[l] && m_ready[l]) begin
            if (exq[l].size() == 0) chk("unexpected_beat", 32'({m_last[l], m_data[l]}), 32'h200);
            else begin
               e = exq[l].pop_front();
               chk("beat", 32'({m_last[l], m_data[l]}), 32'(e[8:0]));
               if (e[11]) chk("grant_id", 32'(gid[l]), 32'(e[10:9]));
            end
         end
         if (terr[l]) tcnt[l]++;
         stall[l] = m_valid[l] && !m_ready[l];
         prev[l] = {m_valid[l], m_last[l], m_data[l]};
         hs[l] = s_valid[l] & s_ready[l];
      end
   endtask
   function automatic bit all_empty();
      bit r;
      r = exq[0].size() == 0 && exq[1].size() == 0 && !m_valid[0] && !m_valid[1];
      for (int q = 0; q < 2*NS; q++) if (sq[q].size() != 0) r = 0;
      return r;
   endfunction
   task automatic drain(input string nm);
      int n;
      n = 0;
      while (n < 300 && !all_empty()) begin
         tick();
         n++;
      end
      chk({nm, "_done"}, 32'(n < 300), 1);
      repeat (2) tick();
      for (int l = 0; l < 2; l++) begin
         chk({nm, "_busy"}, 32'(busy[l]), 0);
         chk({nm, "_timeouts"}, tcnt[l], texp[l]);
      end
   endtask
   task automatic check_zero(input string nm);
      for (int l = 0; l < 2; l++)
         chk(nm, 32'({m_valid[l], m_last[l], m_data[l], s_ready[l], gid[l], busy[l], terr[l]}), 0);
   endtask
   logic [8:0] exp1 [4] = '{9'h0A1, 9'h011, 9'h022, 9'h133};
   initial begin
      for (int l = 0; l < 2; l++) begin
         s_data[l] = '0; s_valid[l] = '0; s_last[l] = '0; m_ready[l] = 1'b1;
         hs[l] = '0; stall[l] = 0; prev[l] = '0; mptr[l] = NS - 1; tcnt[l] = 0; texp[l] = 0;
      end
      for (int q = 0; q < 2*NS; q++) begin gap[q] = 0; gap_len[q] = 0; end
      #12;
      check_zero("reset_state");
      @(negedge clk);
      rst = 1'b0;
      // contention: every source has two one-beat packets
      for (int k = 0; k < 2; k++) for (int i = 0; i < NS; i++) add_pkt(0, i, 1, 8'(16*i + k));
      build(0);
      chk("model_hdr0", 32'(exq[0][0][7:0]), 32'hA0);
      chk("model_hdr1", 32'(exq[0][2][7:0]), 32'hA1);
      chk("model_hdr2", 32'(exq[0][4][7:0]), 32'hA2);
      chk("model_hdr3", 32'(exq[0][6][7:0]), 32'hA3);
      chk("model_hdr4", 32'(exq[0][8][7:0]), 32'hA0);
      drain("contention");
      // single source
      sq[1].push_back(9'h011); sq[1].push_back(9'h022); sq[1].push_back(9'h133);
      build(0);
      chk("model_single_len", exq[0].size(), 4);
      for (int j = 0; j < 4; j++) chk("model_single", 32'(exq[0][j][8:0]), 32'(exp1[j]));
      drain("single");
      // backpressure during a 4-beat packet
      add_pkt(0, 2, 4, 8'h40);
      repeat (5) begin rdyq.push_back(1); rdyq.push_back(0); rdyq.push_back(0); rdyq.push_back(1); end
      build(0);
      drain("backpressure");
      rdyq.delete();
      // forced termination after MAXB beats
      add_pkt(0, 3, 20, 8'd1);
      build(0);
      chk("model_to_len", exq[0].size(), 22);
      chk("model_to_forced", 32'(exq[0][16][8:0]), 32'h110);
      chk("model_to_rehdr", 32'(exq[0][17][7:0]), 32'hA3);
      chk("model_to_count", texp[0], 1);
      drain("timeout");
      // header-less variant with valid gaps
      gap_len[NS] = 3;
      add_pkt(1, 0, 4, 8'h60);
      build(1);
      chk("model_nohdr_len", exq[1].size(), 4);
      chk("model_nohdr_first", 32'(exq[1][0][8:0]), 32'h060);
      drain("nohdr_gaps");
      gap_len[NS] = 0;
      // asynchronous reset after two payload beats
      add_pkt(0, 2, 6, 8'h70);
      build(0);
      begin
         int n;
         n = 0;
         while (n < 50 && exq[0].size() > 4) begin tick(); n++; end
         chk("rst_wait", 32'(n < 50), 1);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_zero("async_reset");
      for (int q = 0; q < 2*NS; q++) begin sq[q].delete(); gap[q] = 0; end
      for (int l = 0; l < 2; l++) begin
         exq[l].delete(); hs[l] = '0; stall[l] = 0; mptr[l] = NS - 1; s_valid[l] = '0;
      end
      @(negedge clk);
      rst = 1'b0;
      add_pkt(0, 3, 2, 8'h80);
      add_pkt(0, 1, 2, 8'h90);
      build(0);
      chk("model_after_rst", 32'(exq[0][0][7:0]), 32'hA1);
      drain("after_reset");
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
